// File: rtl/ntt_row_streamer_pkg.sv
// Shared sizes, coefficient type and FSM state encoding for the NTT row streamer.
package ntt_row_streamer_pkg;

    localparam int N       = 128;
    localparam int COEFF_W = 12;
    localparam int Q       = 3329;
    localparam int LANES   = 2;

    localparam int ROW_W  = $clog2(N);
    localparam int ROWS_W = ROW_W + 1;
    localparam int BEATS  = N / LANES;
    localparam int BEAT_W = $clog2(BEATS);

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_FIN
    } state_e;

    // Requests larger than the memory height stream the whole memory once.
    function automatic logic [ROWS_W-1:0] clampRows(input logic [ROWS_W-1:0] n);
        return (n > ROWS_W'(N)) ? ROWS_W'(N) : n;
    endfunction

endpackage

// File: rtl/ntt_row_streamer_mod_q.sv
// Single conditional subtract: inputs below 2*Q land in [0,Q); ge_q_o marks out-of-range inputs.
module mod_q_cond_sub #(
    parameter int COEFF_W = 12,
    parameter int Q       = 3329
) (
    input  logic [COEFF_W-1:0] c_i,
    output logic [COEFF_W-1:0] red_o,
    output logic               ge_q_o
);

    localparam logic [COEFF_W-1:0] QV = COEFF_W'(Q);

    assign ge_q_o = (c_i >= QV);
    assign red_o  = ge_q_o ? (c_i - QV) : c_i;

endmodule

// File: rtl/ntt_row_streamer.sv
// Walks the coefficient memory row by row, captures each reduced row and streams it
// LANES coefficients per beat over a valid/ready interface.
module ntt_row_streamer
    import ntt_row_streamer_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ROWS_W-1:0] num_rows_i,
    output logic [ROW_W-1:0]  row_o,
    input  coeff_t            row_data_i [N],
    output logic              coeff_valid_o,
    input  logic              coeff_ready_i,
    output coeff_t            coeff_o [LANES],
    output logic [ROW_W-1:0]  row_idx_o,
    output logic              last_in_row_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              range_err_o
);

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROWS_W-1:0] rows_q, rows_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              rangeErr_q, rangeErr_d;
    logic              done_q;
    coeff_t            buf_q [N];

    coeff_t            reduced [N];
    logic              geQ [N];
    logic              anyGe;
    logic              handshake;
    logic              lastBeat;
    logic              lastRow;
    logic [ROW_W-1:0]  laneIdx;

    for (genvar i = 0; i < N; i++) begin : gReduce
        mod_q_cond_sub #(
            .COEFF_W (COEFF_W),
            .Q       (Q)
        ) uRed (
            .c_i    (row_data_i[i]),
            .red_o  (reduced[i]),
            .ge_q_o (geQ[i])
        );
    end

    always_comb begin
        anyGe = 1'b0;
        for (int i = 0; i < N; i++) begin
            anyGe = anyGe | geQ[i];
        end
    end

    assign handshake = (state_q == S_STREAM) && coeff_ready_i;
    assign lastBeat  = (beat_q == BEAT_W'(BEATS - 1));
    assign lastRow   = ({1'b0, row_q} == (rows_q - ROWS_W'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            rows_q     <= '0;
            beat_q     <= '0;
            rangeErr_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rows_q     <= rows_d;
            beat_q     <= beat_d;
            rangeErr_q <= rangeErr_d;
            done_q     <= (state_q == S_FIN);
        end
    end

    // Row memory is combinational from row_o, so the LOAD cycle sees the current row.
    always_ff @(posedge clk_i) begin
        if (state_q == S_LOAD) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= reduced[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        rows_d     = rows_q;
        beat_d     = beat_q;
        rangeErr_d = rangeErr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rows_d     = clampRows(num_rows_i);
                    rangeErr_d = 1'b0;
                    row_d      = '0;
                    state_d    = (clampRows(num_rows_i) == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                beat_d     = '0;
                rangeErr_d = rangeErr_q | anyGe;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (handshake) begin
                    if (lastBeat) begin
                        if (lastRow) begin
                            state_d = S_FIN;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = S_LOAD;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        coeff_valid_o = 1'b0;
        row_idx_o     = '0;
        last_in_row_o = 1'b0;
        last_o        = 1'b0;
        laneIdx       = '0;
        for (int k = 0; k < LANES; k++) begin
            coeff_o[k] = '0;
        end
        if (state_q == S_STREAM) begin
            coeff_valid_o = 1'b1;
            row_idx_o     = row_q;
            last_in_row_o = lastBeat;
            last_o        = lastBeat && lastRow;
            for (int k = 0; k < LANES; k++) begin
                laneIdx    = ROW_W'(int'(beat_q) * LANES + k);
                coeff_o[k] = buf_q[laneIdx];
            end
        end
    end

    assign row_o       = row_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign range_err_o = rangeErr_q;

endmodule

// File: tb/tb_ntt_row_streamer.sv
// Directed bench for ntt_row_streamer: behavioural row memory, hand-derived beat order,
// handshake stalls, row clamping, ignored starts and mid-row reset.
module tb_ntt_row_streamer;
    import ntt_row_streamer_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ROWS_W-1:0] numRows;
    logic [ROW_W-1:0]  rowAddr;
    coeff_t            rowData [N];
    logic              valid;
    logic              ready;
    coeff_t            coeffOut [LANES];
    logic [ROW_W-1:0]  rowIdx;
    logic              lastInRow;
    logic              lastAll;
    logic              busy;
    logic              done;
    logic              rangeErr;

    bit corrupt;
    int nVec;
    int nMis;
    int expRow;
    int expBeat;
    int jobRows;

    always #5 clk = ~clk;

    ntt_row_streamer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .num_rows_i    (numRows),
        .row_o         (rowAddr),
        .row_data_i    (rowData),
        .coeff_valid_o (valid),
        .coeff_ready_i (ready),
        .coeff_o       (coeffOut),
        .row_idx_o     (rowIdx),
        .last_in_row_o (lastInRow),
        .last_o        (lastAll),
        .busy_o        (busy),
        .done_o        (done),
        .range_err_o   (rangeErr)
    );

    // Memory contents: (r*N+c) mod Q, with two out-of-range cells planted in row 0 on demand.
    function automatic int memVal(input int r, input int c, input bit bad);
        if (bad && r == 0 && c == 5) return 4095;
        if (bad && r == 0 && c == 6) return 3329;
        return (r * N + c) % 3329;
    endfunction

    function automatic int refVal(input int r, input int c, input bit bad);
        int m;
        m = memVal(r, c, bad);
        return (m >= 3329) ? m - 3329 : m;
    endfunction

    always_comb begin
        for (int c = 0; c < N; c++) begin
            rowData[c] = coeff_t'(memVal(int'(rowAddr), c, corrupt));
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns at the negedge of the first post-start cycle.
    task automatic applyStimulus(input int n);
        @(negedge clk);
        start   = 1'b1;
        numRows = ROWS_W'(n);
        @(negedge clk);
        start   = 1'b0;
        jobRows = (n > N) ? N : n;
        expRow  = 0;
        expBeat = 0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_row"}, 32'(rowAddr), 0);
        checkOutput({tag, "_valid"}, 32'(valid), 0);
        checkOutput({tag, "_lane0"}, 32'(coeffOut[0]), 0);
        checkOutput({tag, "_lane1"}, 32'(coeffOut[1]), 0);
        checkOutput({tag, "_rowidx"}, 32'(rowIdx), 0);
        checkOutput({tag, "_lastrow"}, 32'(lastInRow), 0);
        checkOutput({tag, "_last"}, 32'(lastAll), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_rerr"}, 32'(rangeErr), 0);
    endtask

    task automatic collectBeats(input int nBeats, input bit rndReady);
        int     got;
        int     guard;
        bit     prevStall;
        coeff_t sav0;
        coeff_t sav1;
        logic [ROW_W-1:0] savRow;
        got       = 0;
        guard     = 0;
        prevStall = 0;
        sav0      = '0;
        sav1      = '0;
        savRow    = '0;
        while (got < nBeats && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (prevStall) begin
                checkOutput("stall_valid", 32'(valid), 1);
                checkOutput("stall_lane0", 32'(coeffOut[0]), 32'(sav0));
                checkOutput("stall_lane1", 32'(coeffOut[1]), 32'(sav1));
                checkOutput("stall_rowidx", 32'(rowIdx), 32'(savRow));
            end
            ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
            prevStall = 0;
            if (valid) begin
                if (ready) begin
                    checkOutput("beat_lane0", 32'(coeffOut[0]), 32'(refVal(expRow, expBeat * 2, corrupt)));
                    checkOutput("beat_lane1", 32'(coeffOut[1]), 32'(refVal(expRow, expBeat * 2 + 1, corrupt)));
                    checkOutput("beat_rowidx", 32'(rowIdx), 32'(expRow));
                    checkOutput("beat_lastrow", 32'(lastInRow), 32'(expBeat == BEATS - 1));
                    checkOutput("beat_last", 32'(lastAll), 32'(expBeat == BEATS - 1 && expRow == jobRows - 1));
                    if (corrupt && expRow == 0 && expBeat == 2)
                        checkOutput("bad_fff_reduced", 32'(coeffOut[1]), 766);
                    if (corrupt && expRow == 0 && expBeat == 3)
                        checkOutput("bad_q_reduced", 32'(coeffOut[0]), 0);
                    got++;
                    if (expBeat == BEATS - 1) begin
                        expBeat = 0;
                        expRow++;
                    end else begin
                        expBeat++;
                    end
                end else begin
                    prevStall = 1;
                    sav0      = coeffOut[0];
                    sav1      = coeffOut[1];
                    savRow    = rowIdx;
                end
            end
        end
        checkOutput("beats_received", 32'(got), 32'(nBeats));
    endtask

    // done_o is expected two cycles after the cycle that carried the final handshake.
    task automatic checkDone(input string tag);
        @(negedge clk);
        checkOutput({tag, "_fin_done"}, 32'(done), 0);
        checkOutput({tag, "_fin_valid"}, 32'(valid), 0);
        @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done), 1);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        @(negedge clk);
        checkOutput({tag, "_done_clr"}, 32'(done), 0);
    endtask

    initial begin
        nVec    = 0;
        nMis    = 0;
        rst     = 1'b1;
        start   = 1'b0;
        numRows = '0;
        ready   = 1'b0;
        corrupt = 1'b0;
        jobRows = 0;
        expRow  = 0;
        expBeat = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkReset("reset");

        $display("[TB] two clean rows, ready held high");
        applyStimulus(2);
        checkOutput("t1_load_valid", 32'(valid), 0);
        checkOutput("t1_load_busy", 32'(busy), 1);
        checkOutput("t1_load_row", 32'(rowAddr), 0);
        collectBeats(2 * BEATS, 1'b0);
        checkOutput("t1_row_o_final", 32'(rowAddr), 1);
        checkDone("t1");
        checkOutput("t1_rerr", 32'(rangeErr), 0);

        $display("[TB] out-of-range cells in row 0");
        corrupt = 1'b1;
        applyStimulus(1);
        collectBeats(BEATS, 1'b0);
        checkDone("t2");
        checkOutput("t2_rerr_set", 32'(rangeErr), 1);
        repeat (3) @(negedge clk);
        checkOutput("t2_rerr_sticky", 32'(rangeErr), 1);
        corrupt = 1'b0;

        $display("[TB] random backpressure");
        applyStimulus(2);
        checkOutput("t3_rerr_cleared", 32'(rangeErr), 0);
        collectBeats(2 * BEATS, 1'b1);
        ready = 1'b1;
        checkDone("t3");

        $display("[TB] zero rows and clamped row count");
        applyStimulus(0);
        checkOutput("t4_zero_fin_done", 32'(done), 0);
        checkOutput("t4_zero_fin_busy", 32'(busy), 1);
        checkOutput("t4_zero_fin_valid", 32'(valid), 0);
        @(negedge clk);
        checkOutput("t4_zero_done", 32'(done), 1);
        checkOutput("t4_zero_valid", 32'(valid), 0);
        checkOutput("t4_zero_busy", 32'(busy), 0);
        applyStimulus(200);
        collectBeats(N * BEATS, 1'b0);
        checkOutput("t4_clamp_row_o", 32'(rowAddr), N - 1);
        checkDone("t4_clamp");

        $display("[TB] ignored start and mid-row reset");
        corrupt = 1'b1;
        applyStimulus(2);
        collectBeats(10, 1'b0);
        start   = 1'b1;
        numRows = ROWS_W'(5);
        collectBeats(1, 1'b0);
        start   = 1'b0;
        collectBeats(5, 1'b0);
        checkOutput("t5_rerr_mid", 32'(rangeErr), 1);
        checkOutput("t5_busy_mid", 32'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkReset("t5_reset");
        corrupt = 1'b0;
        applyStimulus(1);
        checkOutput("t5_restart_row", 32'(rowAddr), 0);
        collectBeats(BEATS, 1'b0);
        checkDone("t5");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
